int_issue_queue: RTL and testbench

- Integer issue queue fed by the dispatcher. It accepts every instruction the decoder steers to the integer path: ALU reg/imm, LUI, AUIPC, branch, JAL and JALR.
- Holds up to DEPTH entries and wakes their source operands by snooping the common data bus (CDB).
- Each cycle it issues the oldest fully-ready entry to the integer execution unit over a valid/ready handshake.

---
 rtl/int_issue_queue_if.sv | 50 +++++
 rtl/int_issue_queue.sv | 136 +++++++++++++
 tb/tb_int_issue_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/int_issue_queue_if.sv
// Dispatch, CDB snoop and issue handshake bundle for the integer issue queue.
// The master side is the dispatcher, CDB and execution unit. The slave side is the queue.
interface int_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 flush;
    logic                 disp_en;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [TAG_W-1:0]     disp_rd_tag;
    logic                 disp_rs1_rdy;
    logic [TAG_W-1:0]     disp_rs1_tag;
    logic [DATA_W-1:0]    disp_rs1_data;
    logic                 disp_rs2_rdy;
    logic [TAG_W-1:0]     disp_rs2_tag;
    logic [DATA_W-1:0]    disp_rs2_data;
    logic                 queue_full;
    logic [CNT_W-1:0]     count;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [TAG_W-1:0]     issue_rd_tag;
    logic [DATA_W-1:0]    issue_rs1_data;
    logic [DATA_W-1:0]    issue_rs2_data;

    modport master (
        output flush, disp_en, disp_payload, disp_rd_tag,
               disp_rs1_rdy, disp_rs1_tag, disp_rs1_data,
               disp_rs2_rdy, disp_rs2_tag, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  queue_full, count, issue_valid, issue_payload, issue_rd_tag,
               issue_rs1_data, issue_rs2_data
    );

    modport slave (
        input  flush, disp_en, disp_payload, disp_rd_tag,
               disp_rs1_rdy, disp_rs1_tag, disp_rs1_data,
               disp_rs2_rdy, disp_rs2_tag, disp_rs2_data,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output queue_full, count, issue_valid, issue_payload, issue_rd_tag,
               issue_rs1_data, issue_rs2_data
    );
endinterface

// File: rtl/int_issue_queue.sv
// Collapsing integer issue queue: slot 0 holds the oldest entry and operands wake from CDB snoop.
// Each cycle the oldest fully-ready entry is offered to the execution unit over valid/ready.
module int_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    int_issue_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     rd_tag;
        logic                 rs1_rdy;
        logic [TAG_W-1:0]     rs1_tag;
        logic [DATA_W-1:0]    rs1_data;
        logic                 rs2_rdy;
        logic [TAG_W-1:0]     rs2_tag;
        logic [DATA_W-1:0]    rs2_data;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    entry_t           woken     [DEPTH];
    entry_t           new_entry;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             queue_full;
    logic             issue_valid;
    logic             fire;
    logic             disp_ok;
    logic             disp_hit1, disp_hit2;

    // Only registered state feeds the select, so a CDB wakeup can issue no earlier than the next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign queue_full  = (count_q == CNT_W'(DEPTH));
    assign issue_valid = sel_found & ~bus.flush;
    assign fire        = issue_valid & bus.issue_ready;
    assign disp_ok     = bus.disp_en & ~queue_full & ~bus.flush;
    assign disp_hit1   = bus.cdb_valid && !bus.disp_rs1_rdy && (bus.cdb_tag == bus.disp_rs1_tag);
    assign disp_hit2   = bus.cdb_valid && !bus.disp_rs2_rdy && (bus.cdb_tag == bus.disp_rs2_tag);
    assign wr_idx      = count_q - CNT_W'(fire);

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.payload  = bus.disp_payload;
        new_entry.rd_tag   = bus.disp_rd_tag;
        new_entry.rs1_rdy  = bus.disp_rs1_rdy | disp_hit1;
        new_entry.rs1_tag  = bus.disp_rs1_tag;
        new_entry.rs1_data = disp_hit1 ? bus.cdb_data : bus.disp_rs1_data;
        new_entry.rs2_rdy  = bus.disp_rs2_rdy | disp_hit2;
        new_entry.rs2_tag  = bus.disp_rs2_tag;
        new_entry.rs2_data = disp_hit2 ? bus.cdb_data : bus.disp_rs2_data;

        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (entries_q[i].valid && bus.cdb_valid) begin
                if (!entries_q[i].rs1_rdy && entries_q[i].rs1_tag == bus.cdb_tag) begin
                    woken[i].rs1_rdy  = 1'b1;
                    woken[i].rs1_data = bus.cdb_data;
                end
                if (!entries_q[i].rs2_rdy && entries_q[i].rs2_tag == bus.cdb_tag) begin
                    woken[i].rs2_rdy  = 1'b1;
                    woken[i].rs2_data = bus.cdb_data;
                end
            end
        end

        // Collapse: everything above the issued slot slides down one, keeping age order.
        for (int i = 0; i < DEPTH - 1; i++) begin
            entries_d[i] = (fire && IDX_W'(i) >= sel_idx) ? woken[i+1] : woken[i];
        end
        entries_d[DEPTH-1] = woken[DEPTH-1];
        if (fire) entries_d[DEPTH-1].valid = 1'b0;

        if (disp_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) entries_d[i] = new_entry;
            end
        end

        count_d = count_q + CNT_W'(disp_ok) - CNT_W'(fire);

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            // NOTE: only valid bits are reset; payload/operand fields are never used while valid is low.
            for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    always_comb begin
        bus.issue_valid    = issue_valid;
        bus.issue_payload  = '0;
        bus.issue_rd_tag   = '0;
        bus.issue_rs1_data = '0;
        bus.issue_rs2_data = '0;
        if (issue_valid) begin
            bus.issue_payload  = entries_q[sel_idx].payload;
            bus.issue_rd_tag   = entries_q[sel_idx].rd_tag;
            bus.issue_rs1_data = entries_q[sel_idx].rs1_data;
            bus.issue_rs2_data = entries_q[sel_idx].rs2_data;
        end
    end

    assign bus.queue_full = queue_full;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed table-driven bench for int_issue_queue.
// Each row sets the inputs for one cycle and lists the outputs expected before that cycle's edge.
module tb_int_issue_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_issue_queue_if #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(32)) bus ();

    int_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        flush;
        logic        disp_en;
        logic [5:0]  rd;
        logic        r1_rdy;
        logic [5:0]  t1;
        logic [31:0] d1;
        logic        r2_rdy;
        logic [5:0]  t2;
        logic [31:0] d2;
        logic        cdb_v;
        logic [5:0]  cdb_t;
        logic [31:0] cdb_d;
        logic        ir;
        logic        e_v;
        logic [5:0]  e_rd;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [2:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   row        = 0;

    function automatic vec_t mk(
        input logic f, input logic de, input logic [5:0] rd,
        input logic r1, input logic [5:0] t1, input logic [31:0] d1,
        input logic r2, input logic [5:0] t2, input logic [31:0] d2,
        input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic ir,
        input logic ev, input logic [5:0] erd, input logic [31:0] ed1, input logic [31:0] ed2,
        input logic [2:0] ecnt, input logic efull);
        vec_t v;
        v.flush = f;  v.disp_en = de; v.rd = rd;
        v.r1_rdy = r1; v.t1 = t1; v.d1 = d1;
        v.r2_rdy = r2; v.t2 = t2; v.d2 = d2;
        v.cdb_v = cv; v.cdb_t = ct; v.cdb_d = cd; v.ir = ir;
        v.e_v = ev; v.e_rd = erd; v.e_d1 = ed1; v.e_d2 = ed2; v.e_cnt = ecnt; v.e_full = efull;
        return v;
    endfunction

    function automatic vec_t idle(input logic ir, input logic ev, input logic [5:0] erd,
                                  input logic [31:0] ed1, input logic [31:0] ed2,
                                  input logic [2:0] ecnt, input logic efull);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, ev, erd, ed1, ed2, ecnt, efull);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (row %0d): got %h, want %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic rst_in);
        @(negedge clk);
        bus.flush         = v.flush;
        bus.disp_en       = v.disp_en;
        bus.disp_payload  = 32'hA000_0000 | 32'(v.rd);
        bus.disp_rd_tag   = v.rd;
        bus.disp_rs1_rdy  = v.r1_rdy;
        bus.disp_rs1_tag  = v.t1;
        bus.disp_rs1_data = v.d1;
        bus.disp_rs2_rdy  = v.r2_rdy;
        bus.disp_rs2_tag  = v.t2;
        bus.disp_rs2_data = v.d2;
        bus.cdb_valid     = v.cdb_v;
        bus.cdb_tag       = v.cdb_t;
        bus.cdb_data      = v.cdb_d;
        bus.issue_ready   = v.ir;
        rst               = rst_in;
        #1;
        check("issue_valid",    32'(bus.issue_valid),    32'(v.e_v));
        check("issue_rd_tag",   32'(bus.issue_rd_tag),   32'(v.e_rd));
        check("issue_payload",  bus.issue_payload,       v.e_v ? (32'hA000_0000 | 32'(v.e_rd)) : 32'h0);
        check("issue_rs1_data", bus.issue_rs1_data,      v.e_d1);
        check("issue_rs2_data", bus.issue_rs2_data,      v.e_d2);
        check("count",          32'(bus.count),          32'(v.e_cnt));
        check("queue_full",     32'(bus.queue_full),     32'(v.e_full));
        row++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and initial state
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0));
        // Two ready entries issue back to back
        vecs.push_back(mk(0,1, 1,1,0,'h11,1,0,'h12, 0,0,0, 1, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1, 2,1,0,'h21,1,0,'h22, 0,0,0, 1, 1,1,'h11,'h12,1,0));
        vecs.push_back(idle(1, 1,2,'h21,'h22,1,0));
        vecs.push_back(idle(1, 0,0,0,0,0,0));
        // A waits on tag 5 (invalid CDB must not wake it); younger B overtakes; CDB wakes A
        vecs.push_back(mk(0,1, 3,0,5,0,1,0,'h32, 0,0,0, 1, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1, 4,1,0,'h41,1,0,'h42, 0,5,'hBAD, 1, 0,0,0,0,1,0));
        vecs.push_back(mk(0,0, 0,0,0,0,0,0,0, 1,5,'h1234, 1, 1,4,'h41,'h42,2,0));
        vecs.push_back(idle(1, 1,3,'h1234,'h32,1,0));
        // Fill to four with issue_ready low; dispatches into a full queue are dropped
        vecs.push_back(mk(0,1, 5,1,0,'h51,1,0,'h52, 0,0,0, 0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1, 6,1,0,'h61,1,0,'h62, 0,0,0, 0, 1,5,'h51,'h52,1,0));
        vecs.push_back(mk(0,1, 7,1,0,'h71,1,0,'h72, 0,0,0, 0, 1,5,'h51,'h52,2,0));
        vecs.push_back(mk(0,1, 8,1,0,'h81,1,0,'h82, 0,0,0, 0, 1,5,'h51,'h52,3,0));
        vecs.push_back(mk(0,1, 9,1,0,'h91,1,0,'h92, 0,0,0, 0, 1,5,'h51,'h52,4,1));
        vecs.push_back(mk(0,1,10,1,0,'hA1,1,0,'hA2, 0,0,0, 1, 1,5,'h51,'h52,4,1));
        vecs.push_back(idle(1, 1,6,'h61,'h62,3,0));
        vecs.push_back(idle(1, 1,7,'h71,'h72,2,0));
        vecs.push_back(idle(1, 1,8,'h81,'h82,1,0));
        // Dispatch operand woken by a same-cycle CDB broadcast
        vecs.push_back(mk(0,1,11,1,0,'hB1,0,9,0, 1,9,'hDEAD, 1, 0,0,0,0,0,0));
        vecs.push_back(idle(1, 1,11,'hB1,'hDEAD,1,0));
        // Flush with simultaneous dispatch and issue_ready
        vecs.push_back(mk(0,1,12,1,0,'hC1,1,0,'hC2, 0,0,0, 0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,13,1,0,'hD1,1,0,'hD2, 0,0,0, 0, 1,12,'hC1,'hC2,1,0));
        vecs.push_back(mk(0,1,14,1,0,'hE1,1,0,'hE2, 0,0,0, 0, 1,12,'hC1,'hC2,2,0));
        vecs.push_back(mk(1,1,15,1,0,'hF1,1,0,'hF2, 0,0,0, 1, 0,0,0,0,3,0));
        vecs.push_back(idle(1, 0,0,0,0,0,0));
        // Issue + dispatch at count 2, then an older entry wakes and takes over the select
        vecs.push_back(mk(0,1,16,1,0,'h601,1,0,'h602, 0,0,0, 0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,17,0,20,0,1,0,'h702, 0,0,0, 0, 1,16,'h601,'h602,1,0));
        vecs.push_back(mk(0,1,18,1,0,'h801,1,0,'h802, 0,0,0, 1, 1,16,'h601,'h602,2,0));
        vecs.push_back(idle(0, 1,18,'h801,'h802,2,0));
        vecs.push_back(mk(0,0, 0,0,0,0,0,0,0, 1,20,'h7777, 0, 1,18,'h801,'h802,2,0));
        vecs.push_back(idle(0, 1,17,'h7777,'h702,2,0));
        vecs.push_back(idle(1, 1,17,'h7777,'h702,2,0));
        vecs.push_back(idle(1, 1,18,'h801,'h802,1,0));
        vecs.push_back(idle(0, 0,0,0,0,0,0));

        bus.flush = 0; bus.disp_en = 0; bus.disp_payload = 0; bus.disp_rd_tag = 0;
        bus.disp_rs1_rdy = 0; bus.disp_rs1_tag = 0; bus.disp_rs1_data = 0;
        bus.disp_rs2_rdy = 0; bus.disp_rs2_tag = 0; bus.disp_rs2_data = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0; bus.issue_ready = 0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) apply(vecs[i], 1'b0);

        // Both operands waiting on the same tag wake from one broadcast
        apply(mk(0,1,20,0,3,0,0,3,0, 0,0,0, 0, 0,0,0,0,0,0), 1'b0);
        apply(mk(0,0, 0,0,0,0,0,0,0, 1,3,'h55, 0, 0,0,0,0,1,0), 1'b0);
        apply(idle(1, 1,20,'h55,'h55,1,0), 1'b0);
        apply(idle(0, 0,0,0,0,0,0), 1'b0);

        // Reset mid-operation clears everything, including a same-cycle dispatch
        apply(mk(0,1,21,1,0,'h211,1,0,'h212, 0,0,0, 0, 0,0,0,0,0,0), 1'b0);
        apply(mk(0,1,22,1,0,'h221,1,0,'h222, 0,0,0, 0, 1,21,'h211,'h212,1,0), 1'b0);
        apply(mk(0,1,23,1,0,'h231,1,0,'h232, 0,0,0, 0, 1,21,'h211,'h212,2,0), 1'b1);
        apply(idle(1, 0,0,0,0,0,0), 1'b0);
        apply(idle(1, 0,0,0,0,0,0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
